sync_fifo_ctl: RTL and testbench

Parametrised single-clock FIFO with concurrent read/write, occupancy level output, programmable almost-full/almost-empty thresholds and sticky-free overflow/underflow pulses. It is the general-purpose buffering block between producer and consumer stages in the datapath. A compile-time option selects first-word-fall-through (FWFT) read behaviour in place of the default registered read.

---
 rtl/sync_fifo_ctl_if.sv | 31 +++
 rtl/sync_fifo_ctl.sv | 98 +++++++++
 tb/tb_sync_fifo_ctl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_ctl_if.sv
// Handshake bundle between a producer/consumer pair and sync_fifo_ctl.
// master = the stage driving requests, slave = the FIFO itself.
interface sync_fifo_ctl_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    logic                     wr_en;
    logic [WIDTH-1:0]         din;
    logic                     rd_en;
    logic [WIDTH-1:0]         dout;
    logic                     dout_valid;
    logic                     full;
    logic                     empty;
    logic                     almost_full;
    logic                     almost_empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     underflow;

    modport master (
        output wr_en, din, rd_en,
        input  dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );

    modport slave (
        input  wr_en, din, rd_en,
        output dout, dout_valid, full, empty, almost_full, almost_empty,
               level, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_ctl.sv
// Single-clock FIFO with level, almost-full/empty thresholds and overflow/underflow pulses.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is a registered read.
module sync_fifo_ctl #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2
) (
    input  logic           clk,
    input  logic           rst,
    sync_fifo_ctl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AFULL  = LW'(AFULL_TH);
    localparam logic [LW-1:0] LVL_AEMPTY = LW'(AEMPTY_TH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    level_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             is_full;
    logic             is_empty;
    logic             rd_acc;
    logic             wr_acc;

    assign is_full  = (level_q == LVL_FULL);
    assign is_empty = (level_q == '0);

    // A read frees a slot in the same cycle, so a full FIFO still takes a concurrent write.
    assign rd_acc = bus.rd_en && !is_empty;
    assign wr_acc = bus.wr_en && (!is_full || rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_acc, rd_acc})
                2'b10:   level_q <= level_q + LW'(1);
                2'b01:   level_q <= level_q - LW'(1);
                default: level_q <= level_q;
            endcase
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    assign bus.dout       = mem[rd_ptr];
    assign bus.dout_valid = !is_empty;
`else
    logic [WIDTH-1:0] dout_q;
    logic             dout_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (rd_acc) begin
                dout_q <= mem[rd_ptr];
            end
            dout_valid_q <= rd_acc;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
`endif

    assign bus.level        = level_q;
    assign bus.full         = is_full;
    assign bus.empty        = is_empty;
    assign bus.almost_full  = (level_q >= LVL_AFULL);
    assign bus.almost_empty = (level_q <= LVL_AEMPTY);
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl: directed scenarios plus random traffic
// against a queue model; a negedge monitor scoreboards read data and all flags.
module tb_sync_fifo_ctl;
    localparam int WIDTH     = 8;
    localparam int DEPTH     = 16;
    localparam int AFULL_TH  = DEPTH - 2;
    localparam int AEMPTY_TH = 2;

    logic clk;
    logic rst;

    sync_fifo_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    sync_fifo_ctl #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    logic [WIDTH-1:0] model_q[$];
    logic [WIDTH-1:0] expect_q[$];
    logic [WIDTH-1:0] exp_dout = '0;
    bit exp_dv  = 0;
    bit exp_ovf = 0;
    bit exp_udf = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of requests, then advances the queue model across the same edge.
    task automatic applyStimulus(input bit wr, input logic [WIDTH-1:0] d, input bit rd, input bit r);
        int  sz;
        bit  racc;
        bit  wacc;
        logic [WIDTH-1:0] v;
        bus.wr_en = wr;
        bus.din   = d;
        bus.rd_en = rd;
        rst       = r;
        @(posedge clk);
        if (r) begin
            model_q.delete();
            expect_q.delete();
            exp_dout = '0;
            exp_dv   = 0;
            exp_ovf  = 0;
            exp_udf  = 0;
        end else begin
            sz   = model_q.size();
            racc = rd && (sz > 0);
            wacc = wr && ((sz < DEPTH) || racc);
            if (racc) begin
                v = model_q.pop_front();
`ifndef FIFO_FWFT_EN
                expect_q.push_back(v);
`endif
                exp_dout = v;
            end
            if (wacc) model_q.push_back(d);
            exp_ovf = wr && !wacc;
            exp_udf = rd && !racc;
            exp_dv  = racc;
        end
        #1;
    endtask

    always @(negedge clk) begin : monitor
        int lvl;
        logic [WIDTH-1:0] v;
        if (checking) begin
            lvl = model_q.size();
            checkOutput("level", int'(bus.level), lvl);
            checkOutput("full", int'(bus.full), int'(lvl == DEPTH));
            checkOutput("empty", int'(bus.empty), int'(lvl == 0));
            checkOutput("almost_full", int'(bus.almost_full), int'(lvl >= AFULL_TH));
            checkOutput("almost_empty", int'(bus.almost_empty), int'(lvl <= AEMPTY_TH));
            checkOutput("overflow", int'(bus.overflow), int'(exp_ovf));
            checkOutput("underflow", int'(bus.underflow), int'(exp_udf));
`ifdef FIFO_FWFT_EN
            checkOutput("dout_valid", int'(bus.dout_valid), int'(lvl != 0));
            if (lvl != 0) checkOutput("dout_fwft", int'(bus.dout), int'(model_q[0]));
`else
            checkOutput("dout_valid", int'(bus.dout_valid), int'(exp_dv));
            if (bus.dout_valid) begin
                if (expect_q.size() == 0) begin
                    checkOutput("dout_spurious", 1, 0);
                end else begin
                    v = expect_q.pop_front();
                    checkOutput("dout", int'(bus.dout), int'(v));
                end
            end else begin
                expect_q.delete();
            end
            checkOutput("dout_hold", int'(bus.dout), int'(exp_dout));
`endif
        end
    end

    initial begin
        int pw;
        int pr;
        bus.wr_en = 0;
        bus.din   = '0;
        bus.rd_en = 0;
        rst       = 1;

        applyStimulus(0, 8'h00, 0, 1);
        applyStimulus(0, 8'h00, 0, 1);
        checking = 1;
        checkOutput("rst_level", int'(bus.level), 0);
        checkOutput("rst_empty", int'(bus.empty), 1);
        checkOutput("rst_full", int'(bus.full), 0);
        checkOutput("rst_aempty", int'(bus.almost_empty), 1);
        checkOutput("rst_afull", int'(bus.almost_full), 0);

        // Fill with 0x01..0x10; almost_full must rise exactly at level 14.
        for (int i = 1; i <= DEPTH; i++) begin
            applyStimulus(1, WIDTH'(i), 0, 0);
            checkOutput("fill_afull", int'(bus.almost_full), int'(i >= 14));
        end
        checkOutput("fill_level", int'(bus.level), 16);
        checkOutput("fill_full", int'(bus.full), 1);
        checkOutput("fill_no_ovf", int'(bus.overflow), 0);

        applyStimulus(1, 8'hAA, 0, 0);
        checkOutput("ovf_pulse", int'(bus.overflow), 1);
        checkOutput("ovf_level", int'(bus.level), 16);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("ovf_one_cycle", int'(bus.overflow), 0);

        // Concurrent read/write while full keeps the level pinned and wraps pointers.
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1, WIDTH'(8'h20 + i), 1, 0);
            checkOutput("rw_full_level", int'(bus.level), 16);
        end

        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(0, 8'h00, 0, 0);
        checkOutput("drain_empty", int'(bus.empty), 1);

        applyStimulus(1, 8'h55, 1, 0);
        checkOutput("udf_pulse", int'(bus.underflow), 1);
        checkOutput("udf_level", int'(bus.level), 1);
        applyStimulus(0, 8'h00, 1, 0);
`ifndef FIFO_FWFT_EN
        checkOutput("udf_read_data", int'(bus.dout), 8'h55);
`endif

        // Reset mid-stream discards contents and ignores the concurrent write.
        for (int i = 0; i < 5; i++) applyStimulus(1, WIDTH'(8'h60 + i), 0, 0);
        applyStimulus(0, 8'h00, 1, 0);
        applyStimulus(1, 8'h70, 0, 1);
        checkOutput("midrst_level", int'(bus.level), 0);
        checkOutput("midrst_empty", int'(bus.empty), 1);
        checkOutput("midrst_dv", int'(bus.dout_valid), 0);
`ifndef FIFO_FWFT_EN
        checkOutput("midrst_dout", int'(bus.dout), 0);
`endif
        applyStimulus(0, 8'h00, 1, 0);
        checkOutput("midrst_udf", int'(bus.underflow), 1);

        // Random traffic; write/read bias changes per phase so both extremes are visited.
        for (int i = 0; i < 10000; i++) begin
            case ((i / 500) % 4)
                0:       begin pw = 70; pr = 30; end
                1:       begin pw = 30; pr = 70; end
                2:       begin pw = 50; pr = 50; end
                default: begin pw = 90; pr = 85; end
            endcase
            applyStimulus($urandom_range(0, 99) < pw, WIDTH'($urandom), $urandom_range(0, 99) < pr,
                          $urandom_range(0, 2999) == 0);
        end

        checking = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
